// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep add/subtract with a segmented carry chain, valid/ready
// handshake with full backpressure, optional signed saturation and carry/overflow/zero flags.
module pipelined_addsub #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;
    logic             en;
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic             c_i [STAGES];
    logic             c_n [STAGES];
    logic             v_i [STAGES];
    logic [WIDTH-1:0] sum_f;
    logic [WIDTH-1:0] res_f;
    logic             ovf_f;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG:0] t;
        if (k == 0) begin : g_first
            assign a_i[k] = op1;
            assign b_i[k] = sub ? ~op2 : op2;
            assign s_i[k] = '0;
            assign c_i[k] = sub;
            assign v_i[k] = in_valid;
        end else begin : g_next
            assign a_i[k] = a_q[k-1];
            assign b_i[k] = b_q[k-1];
            assign s_i[k] = s_q[k-1];
            assign c_i[k] = c_q[k-1];
            assign v_i[k] = v_q[k-1];
        end
        // Unsummed sum bits are still zero, so the new segment is simply OR-ed in.
        assign t      = {1'b0, a_i[k][k*SEG +: SEG]} + {1'b0, b_i[k][k*SEG +: SEG]} + (SEG+1)'(c_i[k]);
        assign s_n[k] = s_i[k] | (WIDTH'(t[SEG-1:0]) << (k * SEG));
        assign c_n[k] = t[SEG];
    end
    assign sum_f = s_n[L];
    assign ovf_f = (a_i[L][WIDTH-1] == b_i[L][WIDTH-1]) && (sum_f[WIDTH-1] != a_i[L][WIDTH-1]);
    assign res_f = (SATURATE != 0 && ovf_f)
                 ? (a_i[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                 : sum_f;
    // The last segment writes straight into the output registers, giving latency STAGES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < L; k++) begin
                v_q[k] <= v_i[k];
                c_q[k] <= c_n[k];
                a_q[k] <= a_i[k];
                b_q[k] <= b_i[k];
                s_q[k] <= s_n[k];
            end
            out_valid <= v_i[L];
            result    <= res_f;
            carry     <= c_n[L];
            overflow  <= ovf_f;
            zero      <= (res_f == '0);
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and random checks of pipelined_addsub against an
// arithmetic reference model, plus latency checks for several pipeline depths.
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [31:0] op1 = '0, op2 = '0;
    logic        m_ir, m_ov, m_c, m_o, m_z;
    logic [31:0] m_res;
    logic        s_ir, s_ov, s_c, s_o, s_z;
    logic [31:0] s_res;

    logic        l_valid = 1'b0, l_sub = 1'b0, l_rdy = 1'b1;
    logic [31:0] l_a = '0, l_b = '0;
    logic        l_ir [4], l_ov [4], l_c [4], l_o [4], l_z [4];
    logic [31:0] l_res [4];
    localparam int ST [4] = '{1, 2, 8, 32};

    int checks = 0, errors = 0, pops = 0;
    logic [64:0] q [$];

    pipelined_addsub #(.WIDTH(32), .STAGES(4), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_ir), .op1(op1), .op2(op2),
        .sub(sub), .out_valid(m_ov), .out_ready(out_ready), .result(m_res), .carry(m_c),
        .overflow(m_o), .zero(m_z));

    pipelined_addsub #(.WIDTH(32), .STAGES(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ir), .op1(op1), .op2(op2),
        .sub(sub), .out_valid(s_ov), .out_ready(out_ready), .result(s_res), .carry(s_c),
        .overflow(s_o), .zero(s_z));

    for (genvar g = 0; g < 4; g++) begin : g_lat
        pipelined_addsub #(.WIDTH(32), .STAGES(ST[g]), .SATURATE(0)) u (
            .clk(clk), .rst_n(rst_n), .in_valid(l_valid), .in_ready(l_ir[g]), .op1(l_a), .op2(l_b),
            .sub(l_sub), .out_valid(l_ov[g]), .out_ready(l_rdy), .result(l_res[g]), .carry(l_c[g]),
            .overflow(l_o[g]), .zero(l_z[g]));
    end

    // Reference: exact signed/unsigned arithmetic in 64 bits, returns {result, carry, ovf, zero}.
    function automatic logic [34:0] model(logic [31:0] x, logic [31:0] y, logic s, bit sat);
        longint      r;
        logic        c, o;
        logic [31:0] res;
        r   = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
        c   = s ? (x >= y) : (({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF);
        o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        res = (sat && o) ? (r < 0 ? 32'h8000_0000 : 32'h7FFF_FFFF) : r[31:0];
        return {res, c, o, res == 32'h0};
    endfunction

    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 7);
        return r == 0 ? 32'h7FFF_FFFF : r == 1 ? 32'h8000_0000 : r == 2 ? 32'hFFFF_FFFF :
               r == 3 ? 32'h0 : $urandom;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: score any output transfer, record any input transfer, advance to edge+1.
    task automatic tick();
        logic [64:0] e;
        logic [34:0] xm, xs;
        if (m_ov && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", m_ov, 0);
            else begin
                e  = q.pop_front();
                pops++;
                xm = model(e[63:32], e[31:0], e[64], 0);
                xs = model(e[63:32], e[31:0], e[64], 1);
                chk("result", m_res, xm[34:3]);
                chk("carry", m_c, xm[2]);
                chk("overflow", m_o, xm[1]);
                chk("zero", m_z, xm[0]);
                chk("sat_valid", s_ov, 1);
                chk("sat_result", s_res, xs[34:3]);
                chk("sat_overflow", s_o, xs[1]);
                chk("sat_zero", s_z, xs[0]);
            end
        end
        if (in_valid && m_ir) begin
            q.push_back({sub, op1, op2});
            chk("sat_in_ready", s_ir, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] a, logic [31:0] b, logic s);
        logic acc;
        int   k = 0;
        in_valid = 1'b1; op1 = a; op2 = b; sub = s;
        do begin
            acc = m_ir;
            tick();
            k++;
        end while (!acc && k < 50);
        chk("push_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && k < 100) begin
            tick();
            k++;
        end
        chk("drained", q.size(), 0);
    endtask

    task automatic latency_main(string tag);
        int n = 1;
        while (!m_ov && n < 40) begin
            tick();
            n++;
        end
        chk(tag, n, 4);
    endtask

    initial begin
        logic [31:0] da [9] = '{32'd3, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'h0000_FFFF, 32'd0, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] db [9] = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'h8000_0000,
                                32'h8000_0000, 32'h1234_5678};
        logic        ds [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] held;
        logic        acc, stalled, stall_done;
        int          i, cyc, p0;
        int          lat [4];

        #12;
        chk("rst_out_valid", m_ov, 0);
        chk("rst_result", m_res, 0);
        chk("rst_carry", m_c, 0);
        chk("rst_overflow", m_o, 0);
        chk("rst_zero", m_z, 0);
        chk("rst_in_ready", m_ir, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        push(32'd5, 32'd7, 1'b0);
        latency_main("latency_basic");
        drain();

        for (int k = 0; k < 9; k++) push(da[k], db[k], ds[k]);
        drain();

        // Backpressure: 8 back-to-back ops, 3-cycle stall once results appear.
        out_ready = 1'b1; i = 0; cyc = 0; stall_done = 1'b0; p0 = pops;
        while ((i < 8 || q.size() > 0) && cyc < 100) begin
            if (m_ov && !stall_done) begin
                out_ready = 1'b0;
                held = m_res;
                repeat (3) begin
                    #1;
                    chk("bp_in_ready", m_ir, 0);
                    chk("bp_valid", m_ov, 1);
                    chk("bp_hold", m_res, held);
                    tick();
                end
                out_ready = 1'b1;
                stall_done = 1'b1;
                #1;
            end
            in_valid = (i < 8);
            if (i < 8) begin op1 = $urandom; op2 = $urandom; sub = 1'($urandom_range(0, 1)); end
            acc = in_valid && m_ir;
            tick();
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", i, 8);
        chk("bp_delivered", pops - p0, 8);
        chk("bp_stalled", stall_done, 1);

        // Random traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op1 = pick(); op2 = pick(); sub = 1'($urandom_range(0, 1));
            #1;
            stalled = m_ov && !out_ready;
            held = m_res;
            tick();
            if (stalled) chk("stall_hold", m_res, held);
        end
        drain();

        // Reset with operations in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; op1 = $urandom; op2 = $urandom; sub = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", m_ov, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", m_ov, 0);
        chk("async_rst_result", m_res, 0);
        chk("async_rst_carry", m_c, 0);
        chk("async_rst_overflow", m_o, 0);
        chk("async_rst_sat_valid", s_ov, 0);
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(32'hDEAD_0001, 32'h0000_FFFF, 1'b0);
        latency_main("latency_after_reset");
        drain();

        // Carry across segments at several depths.
        l_a = 32'h0000_FFFF; l_b = 32'd1; l_valid = 1'b1;
        lat = '{default: 0};
        @(posedge clk);
        #1;
        l_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (l_ov[g] && lat[g] == 0) begin
                    lat[g] = c;
                    chk("lat_result", l_res[g], 32'h0001_0000);
                    chk("lat_carry", l_c[g], 0);
                    chk("lat_overflow", l_o[g], 0);
                    chk("lat_zero", l_z[g], 0);
                    chk("lat_in_ready", l_ir[g], 1);
                end
            end
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < 4; g++) chk("latency_stages", lat[g], ST[g]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
